int_iq_slot_allocator: RTL and testbench
========================================

Name: int_iq_slot_allocator

Overview:
- Tracks occupancy of the integer issue queue slots.
- Picks up to two free slots per cycle for instructions arriving from rename/dispatch, and asserts stall when there is not enough room.
- Frees slots when the issue selector issues them, and frees all slots on recovery flush.
- Sits directly upstream of the int issue queue selector. It produces that stage's dispatch_slot_idx0/1 and dispatch_instr0/1_valid, and consumes its issue_slot_idx0/1 and valids.

Parameters:
- IQ_NUM, default Falco_pkg::INT_IQ_NUM (8): number of issue queue slots.
- IQ_WIDTH, default Falco_pkg::INT_IQ_WIDTH (3): slot index width, equal to clog2(IQ_NUM).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- dispatch_req0  in  1  rename has instr0 ready to enter the queue.
- dispatch_req1  in  1  rename has instr1 ready; only legal together with dispatch_req0.
- recovery_flush  in  1  branch mispredict or exception flush; frees every slot.
- issue_slot_idx0  in  IQ_WIDTH  first issued slot.
- issue_slot_idx1  in  IQ_WIDTH  second issued slot.
- issue_slot_idx0_valid  in  1  issue_slot_idx0 is freed this cycle.
- issue_slot_idx1_valid  in  1  issue_slot_idx1 is freed this cycle.
- dispatch_slot_idx0  out  IQ_WIDTH  slot assigned to instr0.
- dispatch_slot_idx1  out  IQ_WIDTH  slot assigned to instr1.
- dispatch_instr0_valid  out  1  instr0 is granted and written this cycle.
- dispatch_instr1_valid  out  1  instr1 is granted and written this cycle.
- dispatch_stall  out  1  requested instructions cannot all be accepted; rename must hold.
- entry_valid  out  IQ_NUM  registered occupancy bitmap, one bit per slot.
- free_count  out  IQ_WIDTH+1  number of free slots, from registered occupancy.
- stall_cycle_count  out  32  performance counter; see Optional Feature.

Behaviour:
- State: occupancy register occ[IQ_NUM]. Reset value 0. entry_valid = occ.
- Free-slot pick (combinational, from occ only): dispatch_slot_idx0 = lowest index with occ=0; dispatch_slot_idx1 = second-lowest index with occ=0.
  - If no such slot exists, the index is driven to 0.
- free_count = popcount(~occ). Reset value IQ_NUM.
- need = dispatch_req0 + (dispatch_req0 & dispatch_req1). A lone dispatch_req1 is ignored; simulation assertion fires.
- dispatch_stall = (need > free_count) & ~recovery_flush. Acceptance is all-or-nothing; a pair is never split.
- dispatch_instr0_valid = dispatch_req0 & ~dispatch_stall & ~recovery_flush & ~rst.
- dispatch_instr1_valid = dispatch_req0 & dispatch_req1 & ~dispatch_stall & ~recovery_flush & ~rst.
- Latency: grant and index are combinational in the same cycle. The granted slot shows in entry_valid on the next edge.
- Slots freed by issue in cycle N are not reusable until cycle N+1; allocation sees only registered occ. There is no same-cycle bypass.
- Next state, in priority order:
  - rst: occ <= 0.
  - recovery_flush: occ <= 0. Same-cycle dispatch is not granted and same-cycle issue is irrelevant.
  - Otherwise: occ <= (occ & ~issue_mask) | grant_mask. issue_mask has a one-hot bit per valid issue idx; grant_mask has a one-hot bit per granted dispatch idx.
- Dispatch and issue never target the same slot, because allocation picks only free slots.
- Both issue valids naming the same slot frees it once.
- Issue valid on a free slot is a no-op; assertion fires.
- Full queue (free_count=0): any request stalls.
- One free slot: a single request is granted; a pair stalls.
- Reset mid-operation: all outputs return to reset values on the next edge: occ=0, valids 0, stall 0.

Optional Feature:
- Macro INT_IQ_ALLOC_PERF_EN.
- Defined: stall_cycle_count is a 32-bit register, reset 0. It increments by 1 on every cycle with dispatch_stall=1 and saturates at 0xFFFFFFFF. Flush does not clear it.
- Undefined: stall_cycle_count is tied to 0 and no counter logic is generated.

Decomposition:
- Falco_pkg holds INT_IQ_NUM and INT_IQ_WIDTH; nothing new is added.
- Sub-module int_iq_free_slot_finder: purely combinational. Input is the occupancy vector; outputs are the first and second zero-bit indices plus found0/found1 flags.

Test Plan:
- Reset, then req0=req1=1 for 4 cycles with no issue -> slots granted in order (0,1), (2,3), (4,5), (6,7); 5th cycle: stall=1, free_count=0.
- occ=0xFF; issue idx3 valid -> next cycle free_count=1, occ=0xF7. Then req0 only -> granted slot 3. Then req pair with one free -> stall=1, no valids.
- occ=0x0F; same cycle issue idx0 and req pair -> grant slots 4,5, not slot 0. Next occ=0x3E.
- occ=0x5A; recovery_flush with req0=1 -> dispatch_instr0_valid=0. Next occ=0, free_count=8.
- req1=1 with req0=0 on empty queue -> no grants, no stall, assertion fires. occ unchanged.
- INT_IQ_ALLOC_PERF_EN defined: queue full with 10 requesting cycles -> stall_cycle_count=10. Then rst -> 0.

Source files
------------

// File: rtl/Falco_pkg.sv
// Falco_pkg: core-wide sizing constants shared by the integer issue path.
//   INT_IQ_NUM   - number of integer issue queue slots
//   INT_IQ_WIDTH - slot index width, clog2(INT_IQ_NUM)
package Falco_pkg;
    localparam int INT_IQ_NUM   = 8;
    localparam int INT_IQ_WIDTH = 3;
endpackage

// File: rtl/int_iq_free_slot_finder.sv
// int_iq_free_slot_finder: purely combinational search for the two
// lowest-numbered free (zero) bits of an occupancy vector.
// Ports:
//   occ_i     in  IQ_NUM    occupancy, 1 = slot in use
//   idx0_o    out IQ_WIDTH  lowest free slot (0 when none)
//   idx1_o    out IQ_WIDTH  second-lowest free slot (0 when none)
//   found0_o  out 1         idx0_o names a real free slot
//   found1_o  out 1         idx1_o names a real free slot
module int_iq_free_slot_finder #(
    parameter int IQ_NUM   = 8,
    parameter int IQ_WIDTH = 3
) (
    input  logic [IQ_NUM-1:0]   occ_i,
    output logic [IQ_WIDTH-1:0] idx0_o,
    output logic [IQ_WIDTH-1:0] idx1_o,
    output logic                found0_o,
    output logic                found1_o
);

    always_comb begin
        idx0_o   = '0;
        idx1_o   = '0;
        found0_o = 1'b0;
        found1_o = 1'b0;
        // Ascending scan: the first zero claims idx0, the next claims idx1.
        for (int i = 0; i < IQ_NUM; i++) begin
            if (!occ_i[i]) begin
                if (!found0_o) begin
                    idx0_o   = IQ_WIDTH'(i);
                    found0_o = 1'b1;
                end else if (!found1_o) begin
                    idx1_o   = IQ_WIDTH'(i);
                    found1_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/int_iq_slot_allocator.sv
// int_iq_slot_allocator: tracks integer issue queue occupancy, hands out up to
// two free slots per cycle to dispatch, frees slots on issue, clears all on
// recovery flush.
// Optional feature macro: INT_IQ_ALLOC_PERF_EN (saturating stall-cycle counter;
// when undefined stall_cycle_count is tied to 0).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   dispatch_req0/1                rename requests (req1 only with req0)
//   recovery_flush                 free every slot, block dispatch
//   issue_slot_idx0/1(_valid)      slots freed by the issue selector
//   dispatch_slot_idx0/1           slots assigned to instr0/instr1
//   dispatch_instr0/1_valid        grant strobes
//   dispatch_stall                 not enough room, rename must hold
//   entry_valid                    registered occupancy bitmap
//   free_count                     free slots from registered occupancy
//   stall_cycle_count              performance counter
module int_iq_slot_allocator
    import Falco_pkg::*;
#(
    parameter int IQ_NUM   = Falco_pkg::INT_IQ_NUM,
    parameter int IQ_WIDTH = Falco_pkg::INT_IQ_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dispatch_req0,
    input  logic                dispatch_req1,
    input  logic                recovery_flush,
    input  logic [IQ_WIDTH-1:0] issue_slot_idx0,
    input  logic [IQ_WIDTH-1:0] issue_slot_idx1,
    input  logic                issue_slot_idx0_valid,
    input  logic                issue_slot_idx1_valid,
    output logic [IQ_WIDTH-1:0] dispatch_slot_idx0,
    output logic [IQ_WIDTH-1:0] dispatch_slot_idx1,
    output logic                dispatch_instr0_valid,
    output logic                dispatch_instr1_valid,
    output logic                dispatch_stall,
    output logic [IQ_NUM-1:0]   entry_valid,
    output logic [IQ_WIDTH:0]   free_count,
    output logic [31:0]         stall_cycle_count
);

    logic [IQ_NUM-1:0] occ_q;
    logic [IQ_NUM-1:0] occ_d;
    logic [IQ_NUM-1:0] issue_mask;
    logic [IQ_NUM-1:0] grant_mask;
    logic              found0;
    logic              found1;
    logic [1:0]        need;

    // Allocation looks only at registered occupancy: a slot freed by issue
    // this cycle becomes visible to dispatch next cycle.
    int_iq_free_slot_finder #(
        .IQ_NUM   (IQ_NUM),
        .IQ_WIDTH (IQ_WIDTH)
    ) u_finder (
        .occ_i    (occ_q),
        .idx0_o   (dispatch_slot_idx0),
        .idx1_o   (dispatch_slot_idx1),
        .found0_o (found0),
        .found1_o (found1)
    );

    always_comb begin
        free_count = '0;
        for (int i = 0; i < IQ_NUM; i++) begin
            free_count = free_count + (IQ_WIDTH + 1)'(!occ_q[i]);
        end
    end

    // A lone req1 contributes nothing; pairs are accepted all-or-nothing.
    assign need = {1'b0, dispatch_req0} + {1'b0, dispatch_req0 & dispatch_req1};

    assign dispatch_stall        = ((IQ_WIDTH + 1)'(need) > free_count) & ~recovery_flush;
    assign dispatch_instr0_valid = dispatch_req0 & ~dispatch_stall & ~recovery_flush & ~rst;
    assign dispatch_instr1_valid = dispatch_req0 & dispatch_req1 & ~dispatch_stall
                                   & ~recovery_flush & ~rst;

    assign entry_valid = occ_q;

    // Both issue ports naming the same slot simply OR into one bit.
    // Grants are additionally qualified by the finder's found flags so a
    // stray grant can never set a slot that was not actually free.
    generate
        for (genvar gi = 0; gi < IQ_NUM; gi++) begin : g_masks
            assign issue_mask[gi] =
                (issue_slot_idx0_valid && (issue_slot_idx0 == IQ_WIDTH'(gi))) ||
                (issue_slot_idx1_valid && (issue_slot_idx1 == IQ_WIDTH'(gi)));
            assign grant_mask[gi] =
                (dispatch_instr0_valid && found0 && (dispatch_slot_idx0 == IQ_WIDTH'(gi))) ||
                (dispatch_instr1_valid && found1 && (dispatch_slot_idx1 == IQ_WIDTH'(gi)));
        end
    endgenerate

    always_comb begin
        occ_d = (occ_q & ~issue_mask) | grant_mask;
        if (recovery_flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef INT_IQ_ALLOC_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating; flush leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (dispatch_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycle_count = stall_cnt_q;
`else
    assign stall_cycle_count = 32'd0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dispatch_req1 && !dispatch_req0))
                else $warning("int_iq_slot_allocator: dispatch_req1 without dispatch_req0 ignored");
            if (!recovery_flush) begin
                assert (!(issue_slot_idx0_valid && !occ_q[issue_slot_idx0]))
                    else $warning("int_iq_slot_allocator: issue idx0 names a free slot");
                assert (!(issue_slot_idx1_valid && !occ_q[issue_slot_idx1]))
                    else $warning("int_iq_slot_allocator: issue idx1 names a free slot");
            end
        end
    end
`endif

endmodule

// File: tb/tb_int_iq_slot_allocator.sv
// Directed-vector bench for int_iq_slot_allocator. The stimulus process drives
// one vector per cycle and queues its hand-computed expectation; the monitor
// pops on the falling edge and compares against the DUT outputs.
module tb_int_iq_slot_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic       dispatch_req0, dispatch_req1, recovery_flush;
    logic [2:0] issue_slot_idx0, issue_slot_idx1;
    logic       issue_slot_idx0_valid, issue_slot_idx1_valid;
    logic [2:0] dispatch_slot_idx0, dispatch_slot_idx1;
    logic       dispatch_instr0_valid, dispatch_instr1_valid, dispatch_stall;
    logic [7:0] entry_valid;
    logic [3:0] free_count;
    logic [31:0] stall_cycle_count;

    int checks   = 0;
    int failures = 0;
    int scc_model = 0;
    int txn = 0;

    typedef struct {
        bit rst, fl, r0, r1, iv0, iv1;
        int ii0, ii1;
        bit ev0, ev1;
        int ei0, ei1;
        bit es;
        int eocc, efc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    int_iq_slot_allocator dut (
        .clk                   (clk),
        .rst                   (rst),
        .dispatch_req0         (dispatch_req0),
        .dispatch_req1         (dispatch_req1),
        .recovery_flush        (recovery_flush),
        .issue_slot_idx0       (issue_slot_idx0),
        .issue_slot_idx1       (issue_slot_idx1),
        .issue_slot_idx0_valid (issue_slot_idx0_valid),
        .issue_slot_idx1_valid (issue_slot_idx1_valid),
        .dispatch_slot_idx0    (dispatch_slot_idx0),
        .dispatch_slot_idx1    (dispatch_slot_idx1),
        .dispatch_instr0_valid (dispatch_instr0_valid),
        .dispatch_instr1_valid (dispatch_instr1_valid),
        .dispatch_stall        (dispatch_stall),
        .entry_valid           (entry_valid),
        .free_count            (free_count),
        .stall_cycle_count     (stall_cycle_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s txn=%0d actual=0x%0h required=0x%0h", name, txn, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit fl, input bit r0, input bit r1,
                       input bit iv0, input int ii0, input bit iv1, input int ii1,
                       input bit ev0, input bit ev1, input int ei0, input int ei1,
                       input bit es, input int eocc, input int efc);
        vec_t v;
        v.rst = r; v.fl = fl; v.r0 = r0; v.r1 = r1;
        v.iv0 = iv0; v.ii0 = ii0; v.iv1 = iv1; v.ii1 = ii1;
        v.ev0 = ev0; v.ev1 = ev1; v.ei0 = ei0; v.ei1 = ei1;
        v.es = es; v.eocc = eocc; v.efc = efc;
        vecs.push_back(v);
    endtask

    // Monitor: compare every output against the queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t e;
            int scc_exp;
            e = sb.pop_front();
`ifdef INT_IQ_ALLOC_PERF_EN
            scc_exp = scc_model;
`else
            scc_exp = 0;
`endif
            chk("instr0_valid", int'(dispatch_instr0_valid), int'(e.ev0));
            chk("instr1_valid", int'(dispatch_instr1_valid), int'(e.ev1));
            chk("slot_idx0",    int'(dispatch_slot_idx0),    e.ei0);
            chk("slot_idx1",    int'(dispatch_slot_idx1),    e.ei1);
            chk("stall",        int'(dispatch_stall),        int'(e.es));
            chk("entry_valid",  int'(entry_valid),           e.eocc);
            chk("free_count",   int'(free_count),            e.efc);
            chk("stall_count",  int'(stall_cycle_count),     scc_exp);
            $display("txn %0d rst=%0d fl=%0d req=%0d%0d occ=%02h fc=%0d v=%0d%0d idx=%0d,%0d stall=%0d scc=%0d",
                     txn, e.rst, e.fl, e.r0, e.r1, entry_valid, free_count,
                     dispatch_instr0_valid, dispatch_instr1_valid,
                     dispatch_slot_idx0, dispatch_slot_idx1, dispatch_stall, stall_cycle_count);
            if (e.rst) scc_model = 0;
            else if (e.es) scc_model++;
            txn++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //  rst fl r0 r1 iv0 ii0 iv1 ii1 | v0 v1 i0 i1 st occ  fc
        add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 'h00, 8); // reset state
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 'h00, 8);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 2, 3, 0, 'h03, 6);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 4, 5, 0, 'h0F, 4);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 6, 7, 0, 'h3F, 2);
        add(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 'hFF, 0); // full -> stall
        add(0, 0, 0, 0, 1, 3, 0, 0,   0, 0, 0, 0, 0, 'hFF, 0); // issue slot 3
        add(0, 0, 1, 0, 0, 0, 0, 0,   1, 0, 3, 0, 0, 'hF7, 1); // single fits
        add(0, 0, 0, 0, 1, 1, 1, 1,   0, 0, 0, 0, 0, 'hFF, 0); // dup issue slot 1
        add(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 1, 'hFD, 1); // pair, one free
        add(0, 0, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 'hFD, 1);
        add(1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 'hFF, 0); // reset mid-op
        add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 'h00, 8);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 'h00, 8);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 2, 3, 0, 'h03, 6);
        add(0, 0, 1, 1, 1, 0, 0, 0,   1, 1, 4, 5, 0, 'h0F, 4); // no same-cycle reuse
        add(0, 0, 0, 0, 1, 2, 1, 5,   0, 0, 0, 6, 0, 'h3E, 3);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 2, 0, 'h1A, 5);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 5, 6, 0, 'h1F, 3);
        add(0, 0, 0, 0, 1, 0, 1, 2,   0, 0, 7, 0, 0, 'h7F, 1);
        add(0, 0, 0, 0, 1, 5, 0, 0,   0, 0, 0, 2, 0, 'h7A, 3);
        add(0, 1, 1, 0, 1, 1, 0, 0,   0, 0, 0, 2, 0, 'h5A, 4); // flush
        add(0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 'h00, 8); // lone req1
        add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 'h00, 8);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 1, 0, 'h00, 8);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 2, 3, 0, 'h03, 6);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 4, 5, 0, 'h0F, 4);
        add(0, 0, 1, 1, 0, 0, 0, 0,   1, 1, 6, 7, 0, 'h3F, 2);
        for (int k = 0; k < 10; k++)
            add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hFF, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 'hFF, 0); // counter holds 10 here
        add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 'h00, 8);

        rst = 1'b1;
        dispatch_req0 = 1'b0; dispatch_req1 = 1'b0; recovery_flush = 1'b0;
        issue_slot_idx0 = '0; issue_slot_idx1 = '0;
        issue_slot_idx0_valid = 1'b0; issue_slot_idx1_valid = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[n]) begin
            rst                   = vecs[n].rst;
            recovery_flush        = vecs[n].fl;
            dispatch_req0         = vecs[n].r0;
            dispatch_req1         = vecs[n].r1;
            issue_slot_idx0_valid = vecs[n].iv0;
            issue_slot_idx0       = 3'(vecs[n].ii0);
            issue_slot_idx1_valid = vecs[n].iv1;
            issue_slot_idx1       = 3'(vecs[n].ii1);
            sb.push_back(vecs[n]);
            @(posedge clk); #1;
        end

        rst = 1'b0; recovery_flush = 1'b0;
        dispatch_req0 = 1'b0; dispatch_req1 = 1'b0;
        issue_slot_idx0_valid = 1'b0; issue_slot_idx1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
